// File: rtl/ptw_pkg.sv
// Shared types and widths for the page-table-walk arbiter.
// State encoding, table widths and the coalescing VPN compare.
package ptw_pkg;

    localparam int VPN_W   = 6;
    localparam int VPN32_W = 4;
    localparam int PA8_W   = 12;
    localparam int PA32_W  = 8;
    localparam int RSP_W   = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } ptw_state_e;

    // 32B table only decodes the upper VPN bits.
    function automatic logic vpn_match(
        input logic             size,
        input logic [VPN_W-1:0] a,
        input logic [VPN_W-1:0] b
    );
        if (size) begin
            return a[VPN_W-1:2] == b[VPN_W-1:2];
        end
        return a == b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr,
// wrapping; returns a one-hot grant and its index.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (IW'(i) >= ptr)) begin
                gnt[i] = 1'b1;
                idx    = IW'(i);
                any    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                gnt[i] = 1'b1;
                idx    = IW'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ptw_arbiter.sv
// Shares the 8B and 32B page tables between NUM_REQ TLBs, one walk at a time.
// Define PTW_COALESCE_EN to answer matching waiting requesters with the same walk.
module ptw_arbiter
    import ptw_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     RST_N,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    input  logic [NUM_REQ-1:0]       REQ_SIZE,
    input  logic [VPN_W*NUM_REQ-1:0] REQ_VPN,
    output logic [NUM_REQ-1:0]       RSP_VALID,
    output logic                     RSP_ERR,
    output logic [RSP_W-1:0]         RSP_DATA,
    output logic                     PAGE_8B_RQST,
    output logic [VPN_W-1:0]         PAGE_8B_LOOKUP,
    input  logic [PA8_W-1:0]         PAGE_8B_RECV,
    input  logic                     PAGE_8B_COMPLETE,
    output logic                     PAGE_32B_RQST,
    output logic [VPN32_W-1:0]       PAGE_32B_LOOKUP,
    input  logic [PA32_W-1:0]        PAGE_32B_RECV,
    input  logic                     PAGE_32B_COMPLETE
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    ptw_state_e         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_REQ-1:0] own_q, own_d;
    logic               size_q, size_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RSP_W-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic               rq8_q, rq8_d;
    logic [VPN_W-1:0]   lk8_q, lk8_d;
    logic               rq32_q, rq32_d;
    logic [VPN32_W-1:0] lk32_q, lk32_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [RSP_W-1:0]   rsp_data_q, rsp_data_d;

    logic [VPN_W-1:0]   vpn_arr [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               gnt_size;
    logic [VPN_W-1:0]   gnt_vpn;
    logic               sel_complete;
    logic [RSP_W-1:0]   sel_recv;
    logic               timed_out;
    logic [IW-1:0]      next_ptr;
    logic [NUM_REQ-1:0] coal;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            vpn_arr[i] = REQ_VPN[i*VPN_W +: VPN_W];
        end
    end

    // A requester is still high during its own response cycle; keep it out.
    assign eligible = REQ_VALID & ~rsp_valid_q;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req (eligible),
        .ptr (ptr_q),
        .gnt (gnt_oh),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign gnt_size     = REQ_SIZE[gnt_idx];
    assign gnt_vpn      = vpn_arr[gnt_idx];
    assign sel_complete = size_q ? PAGE_32B_COMPLETE : PAGE_8B_COMPLETE;
    assign sel_recv     = size_q ? {{(RSP_W-PA32_W){1'b0}}, PAGE_32B_RECV}
                                 : PAGE_8B_RECV;
    assign timed_out    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign next_ptr     = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

`ifdef PTW_COALESCE_EN
    logic [VPN_W-1:0] vpn_q, vpn_d;

    always_comb begin
        vpn_d = vpn_q;
        if (state_q == ST_IDLE && gnt_any) begin
            vpn_d = gnt_vpn;
        end
        coal = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            coal[i] = REQ_VALID[i] && (REQ_SIZE[i] == size_q)
                   && vpn_match(size_q, vpn_arr[i], vpn_q);
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            vpn_q <= '0;
        end else begin
            vpn_q <= vpn_d;
        end
    end
`else
    assign coal = '0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        own_d       = own_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        err_d       = err_q;
        rq8_d       = rq8_q;
        lk8_d       = lk8_q;
        rq32_d      = rq32_q;
        lk32_d      = lk32_q;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    state_d = ST_WAIT;
                    idx_d   = gnt_idx;
                    own_d   = gnt_oh;
                    size_d  = gnt_size;
                    cnt_d   = '0;
                    data_d  = '0;
                    err_d   = 1'b0;
                    rq8_d   = !gnt_size;
                    lk8_d   = gnt_size ? '0 : gnt_vpn;
                    rq32_d  = gnt_size;
                    lk32_d  = gnt_size ? gnt_vpn[VPN_W-1:2] : '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (sel_complete || timed_out) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    data_d  = sel_complete ? sel_recv : '0;
                    err_d   = !sel_complete;
                    rq8_d   = 1'b0;
                    lk8_d   = '0;
                    rq32_d  = 1'b0;
                    lk32_d  = '0;
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                rsp_valid_d = own_q | coal;
                rsp_err_d   = err_q;
                rsp_data_d  = data_q;
                ptr_d       = next_ptr;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            own_q       <= '0;
            size_q      <= 1'b0;
            cnt_q       <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            rq8_q       <= 1'b0;
            lk8_q       <= '0;
            rq32_q      <= 1'b0;
            lk32_q      <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            own_q       <= own_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            err_q       <= err_d;
            rq8_q       <= rq8_d;
            lk8_q       <= lk8_d;
            rq32_q      <= rq32_d;
            lk32_q      <= lk32_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign RSP_VALID       = rsp_valid_q;
    assign RSP_ERR         = rsp_err_q;
    assign RSP_DATA        = rsp_data_q;
    assign PAGE_8B_RQST    = rq8_q;
    assign PAGE_8B_LOOKUP  = lk8_q;
    assign PAGE_32B_RQST   = rq32_q;
    assign PAGE_32B_LOOKUP = lk32_q;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Bench for ptw_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ptw_arbiter;

    localparam int N  = 2;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_size = '0;
    logic [5:0]  vpn [2];
    logic [11:0] req_vpn_bus;
    logic [11:0] recv8 = '0;
    logic        cmp8 = 1'b0;
    logic [7:0]  recv32 = '0;
    logic        cmp32 = 1'b0;

    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [11:0] rsp_data;
    logic        rq8;
    logic [5:0]  lk8;
    logic        rq32;
    logic [3:0]  lk32;

    int checks = 0;
    int errors = 0;

    assign req_vpn_bus = {vpn[1], vpn[0]};

    always #5 clk = ~clk;

    ptw_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .RST_N             (rst_n),
        .REQ_VALID         (req_valid),
        .REQ_SIZE          (req_size),
        .REQ_VPN           (req_vpn_bus),
        .RSP_VALID         (rsp_valid),
        .RSP_ERR           (rsp_err),
        .RSP_DATA          (rsp_data),
        .PAGE_8B_RQST      (rq8),
        .PAGE_8B_LOOKUP    (lk8),
        .PAGE_8B_RECV      (recv8),
        .PAGE_8B_COMPLETE  (cmp8),
        .PAGE_32B_RQST     (rq32),
        .PAGE_32B_LOOKUP   (lk32),
        .PAGE_32B_RECV     (recv32),
        .PAGE_32B_COMPLETE (cmp32)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit same_page(input logic sz, input logic [5:0] a,
                                     input logic [5:0] b);
        return sz ? ((a >> 2) == (b >> 2)) : (a == b);
    endfunction

    // Reference model: a walk is busy, then has an answer ready, then answers.
    bit          m_busy = 0;
    bit          m_ready = 0;
    bit          m_done = 0;
    int          m_owner = 0;
    int          m_age = 0;
    int          m_rr = 0;
    logic        m_size = 1'b0;
    logic [5:0]  m_vpn = '0;
    logic [11:0] m_res = '0;
    logic        m_err = 1'b0;
    logic [1:0]  m_shown = '0;
    logic [1:0]  e_valid = '0;
    logic        e_err = 1'b0;
    logic [11:0] e_data = '0;
    logic        e_rq8 = 1'b0;
    logic        e_rq32 = 1'b0;
    logic [5:0]  e_lk8 = '0;
    logic [3:0]  e_lk32 = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_ready = 0; m_rr = 0; m_age = 0;
            e_valid = '0; e_err = 1'b0; e_data = '0;
            e_rq8 = 1'b0; e_rq32 = 1'b0; e_lk8 = '0; e_lk32 = '0;
        end else begin
            m_shown = e_valid;
            e_valid = '0; e_err = 1'b0; e_data = '0;
            if (m_busy) begin
                m_age++;
                m_done = m_size ? cmp32 : cmp8;
                if (m_done || m_age == TO) begin
                    m_res = m_done ? (m_size ? {4'h0, recv32} : recv8) : 12'h0;
                    m_err = !m_done;
                    m_busy = 0; m_ready = 1;
                    e_rq8 = 1'b0; e_rq32 = 1'b0; e_lk8 = '0; e_lk32 = '0;
                end
            end else if (m_ready) begin
                m_ready = 0;
                e_valid[m_owner] = 1'b1;
                e_err = m_err;
                e_data = m_res;
                m_rr = (m_owner + 1) % N;
`ifdef PTW_COALESCE_EN
                for (int j = 0; j < N; j++) begin
                    if (req_valid[j] && req_size[j] == m_size
                        && same_page(m_size, vpn[j], m_vpn))
                        e_valid[j] = 1'b1;
                end
`endif
            end else begin
                m_done = 0;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (!m_done && req_valid[c] && !m_shown[c]) begin
                        m_done = 1; m_busy = 1; m_age = 0; m_owner = c;
                        m_size = req_size[c]; m_vpn = vpn[c];
                        if (m_size) begin
                            e_rq32 = 1'b1; e_lk32 = m_vpn[5:2];
                        end else begin
                            e_rq8 = 1'b1; e_lk8 = m_vpn;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("m_rsp_valid", 32'(rsp_valid), 32'(e_valid));
        check("m_rsp_err", 32'(rsp_err), 32'(e_err));
        check("m_rsp_data", 32'(rsp_data), 32'(e_data));
        check("m_rq8", 32'(rq8), 32'(e_rq8));
        check("m_lk8", 32'(lk8), 32'(e_lk8));
        check("m_rq32", 32'(rq32), 32'(e_rq32));
        check("m_lk32", 32'(lk32), 32'(e_lk32));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_rqst(input int budget, output int cyc);
        cyc = 0;
        while (!(rq8 || rq32) && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check("rqst_seen", 32'(rq8 | rq32), 32'd1);
    endtask

    task automatic pulse8(input logic [11:0] d);
        recv8 = d; cmp8 = 1'b1;
        tick(1);
        recv8 = '0; cmp8 = 1'b0;
    endtask

    task automatic pulse32(input logic [7:0] d);
        recv32 = d; cmp32 = 1'b1;
        tick(1);
        recv32 = '0; cmp32 = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, input bit hold,
                            output logic [1:0] v, output logic [11:0] d,
                            output logic e, output int cyc);
        cyc = 0;
        while (rsp_valid == '0 && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check("rsp_seen", 32'(rsp_valid != '0), 32'd1);
        v = rsp_valid; d = rsp_data; e = rsp_err;
        if (!hold) req_valid = req_valid & ~rsp_valid;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  v;
        logic [11:0] d;
        logic        e;
        int          cyc;
        int          g [4];

        vpn[0] = '0; vpn[1] = '0;
        tick(3);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rq8", 32'(rq8), 32'd0);
        check("reset_rq32", 32'(rq32), 32'd0);
        check("reset_lk8", 32'(lk8), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: single 8B walk; a VPN change after grant is ignored
        vpn[0] = 6'h2A; req_size = 2'b00; req_valid = 2'b01;
        wait_rqst(5, cyc);
        check("t1_grant_latency", 32'(cyc), 32'd1);
        check("t1_lk8", 32'(lk8), 32'h2A);
        check("t1_rq32", 32'(rq32), 32'd0);
        vpn[0] = 6'h15;
        tick(1);
        check("t1_lk8_held", 32'(lk8), 32'h2A);
        pulse8(12'h5C3);
        check("t1_rq8_drop", 32'(rq8), 32'd0);
        wait_rsp(5, 0, v, d, e, cyc);
        check("t1_rsp_latency", 32'(cyc), 32'd1);
        check("t1_valid", 32'(v), 32'h1);
        check("t1_data", 32'(d), 32'h5C3);
        check("t1_err", 32'(e), 32'd0);
        tick(2);

        // 2: single 32B walk from requester 1
        vpn[1] = 6'b1011_01; req_size = 2'b10; req_valid = 2'b10;
        wait_rqst(5, cyc);
        check("t2_lk32", 32'(lk32), 32'hB);
        check("t2_rq8", 32'(rq8), 32'd0);
        pulse32(8'h7E);
        wait_rsp(5, 0, v, d, e, cyc);
        check("t2_valid", 32'(v), 32'h2);
        check("t2_data", 32'(d), 32'h07E);
        check("t2_err", 32'(e), 32'd0);
        tick(2);

        // 3: both held, 1-cycle table -> alternating grants
        req_size = 2'b00; vpn[0] = 6'h01; vpn[1] = 6'h02; req_valid = 2'b11;
        for (int w = 0; w < 4; w++) begin
            wait_rqst(5, cyc);
            pulse8({6'h0, lk8});
            wait_rsp(5, 1, v, d, e, cyc);
            g[w] = (v == 2'b10) ? 1 : ((v == 2'b01) ? 0 : 9);
            check("t3_data", 32'(d), 32'(vpn[g[w] & 1]));
        end
        req_valid = 2'b00;
        check("t3_grant0", 32'(g[0]), 32'd0);
        check("t3_grant1", 32'(g[1]), 32'd1);
        check("t3_grant2", 32'(g[2]), 32'd0);
        check("t3_grant3", 32'(g[3]), 32'd1);
        tick(2);

        // 4: timeout, then a late reply at cycle 70 is dropped
        vpn[0] = 6'h3F; req_valid = 2'b01;
        wait_rqst(5, cyc);
        wait_rsp(100, 0, v, d, e, cyc);
        check("t4_timeout_cycles", 32'(cyc), 32'd65);
        check("t4_valid", 32'(v), 32'h1);
        check("t4_err", 32'(e), 32'd1);
        check("t4_data", 32'(d), 32'd0);
        tick(4);
        pulse8(12'h123);
        tick(2);
        check("t4_late_valid", 32'(rsp_valid), 32'd0);
        check("t4_late_rq8", 32'(rq8), 32'd0);

        // 5: reset mid-walk, held request re-granted afterwards
        vpn[0] = 6'h05; req_valid = 2'b01;
        wait_rqst(5, cyc);
        tick(3);
        rst_n = 1'b0;
        #1;
        check("t5_rq8_in_reset", 32'(rq8), 32'd0);
        check("t5_lk8_in_reset", 32'(lk8), 32'd0);
        check("t5_valid_in_reset", 32'(rsp_valid), 32'd0);
        tick(2);
        rst_n = 1'b1;
        wait_rqst(5, cyc);
        check("t5_regrant_latency", 32'(cyc), 32'd1);
        check("t5_lk8", 32'(lk8), 32'h05);
        pulse8(12'hA5A);
        wait_rsp(5, 0, v, d, e, cyc);
        check("t5_valid", 32'(v), 32'h1);
        check("t5_data", 32'(d), 32'hA5A);
        tick(2);

        // 6: both ask for the same 8B page
        vpn[0] = 6'h11; vpn[1] = 6'h11; req_size = 2'b00; req_valid = 2'b11;
`ifdef PTW_COALESCE_EN
        wait_rqst(5, cyc);
        pulse8(12'h0AB);
        wait_rsp(5, 0, v, d, e, cyc);
        check("t6_valid", 32'(v), 32'h3);
        check("t6_data", 32'(d), 32'h0AB);
        tick(3);
        check("t6_no_second_walk", 32'(rq8), 32'd0);
`else
        wait_rqst(5, cyc);
        pulse8(12'h0AB);
        wait_rsp(5, 0, v, d, e, cyc);
        check("t6_first_valid", 32'(v), 32'h2);
        check("t6_first_data", 32'(d), 32'h0AB);
        wait_rqst(5, cyc);
        check("t6_second_latency", 32'(cyc), 32'd1);
        pulse8(12'h0CD);
        wait_rsp(5, 0, v, d, e, cyc);
        check("t6_second_valid", 32'(v), 32'h1);
        check("t6_second_data", 32'(d), 32'h0CD);
`endif
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
